// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detect, 3-point majority bit recovery, LSB-first deserialize, parity/stop check.
// Optional RX_SYNC_EN: inserts a 2-flop synchronizer (reset high) ahead of all RX_IN consumers.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [PRESC_WIDTH-1:0] prescaler,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] edge_counter,
  input  logic [3:0]             bit_counter,
  output logic                   cnt_enable,
  output logic [DATA_WIDTH-1:0]  P_DATA,
  output logic                   data_valid,
  output logic                   par_err,
  output logic                   stp_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH + 1);

  state_t                 state;
  logic                   rx;
  logic [2:0]             samp;
  logic                   par_en_q, par_typ_q;
  logic [PRESC_WIDTH-1:0] half;
  logic                   at_s0, at_s1, at_s2, at_dp, at_end, bit_maj;

`ifdef RX_SYNC_EN
  logic [1:0] rx_sync;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], RX_IN};
  end
  assign rx = rx_sync[1];
`else
  assign rx = RX_IN;
`endif

  assign half    = prescaler >> 1;
  assign at_s0   = edge_counter == half - PRESC_WIDTH'(1);
  assign at_s1   = edge_counter == half;
  assign at_s2   = edge_counter == half + PRESC_WIDTH'(1);
  assign at_dp   = edge_counter == half + PRESC_WIDTH'(2);
  assign at_end  = edge_counter == prescaler;
  assign bit_maj = (samp[0] & samp[1]) | (samp[1] & samp[2]) | (samp[0] & samp[2]);

  assign cnt_enable = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);

  // Samples refresh every bit; outside a frame the counter sits at 1 so none fire.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp <= '0;
    end else begin
      if (at_s0) samp[0] <= rx;
      if (at_s1) samp[1] <= rx;
      if (at_s2) samp[2] <= rx;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (!rx) begin
            state     <= START;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_err   <= 1'b0;
            stp_err   <= 1'b0;
            P_DATA    <= '0;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (at_dp && bit_maj)                      state <= IDLE;
          else if (at_end && bit_counter == 4'd1)    state <= DATA;
        end
        DATA: begin
          if (at_dp)
            for (int i = 0; i < DATA_WIDTH; i++)
              if (bit_counter == 4'(i + 2)) P_DATA[i] <= bit_maj;
          if (at_end && bit_counter == LAST_DATA)
            state <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          if (at_dp)  par_err <= bit_maj != (^P_DATA ^ par_typ_q);
          if (at_end) state   <= STOP;
        end
        STOP: begin
          // Leave at mid-stop so a slightly fast transmitter's next start is not missed.
          if (at_dp) begin
            stp_err    <= ~bit_maj;
            data_valid <= bit_maj & ~par_err;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: models the upstream edge/bit counter and predicts frame results from the line waveform.
module tb_uart_rx_frame_ctrl;

`ifdef RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       CLK = 0, RST = 0, RX_IN = 1, PAR_EN = 0, PAR_TYP = 0;
  logic [5:0] prescaler = 6'd8;
  logic [5:0] edge_counter;
  logic [3:0] bit_counter;
  logic       cnt_enable, data_valid, par_err, stp_err;
  logic [7:0] P_DATA;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescaler(prescaler),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .edge_counter(edge_counter),
    .bit_counter(bit_counter), .cnt_enable(cnt_enable), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  // Upstream counter: holds 1/1 while disabled, edges 1..prescaler, bit advances on the last edge.
  always @(posedge CLK or negedge RST) begin
    if (!RST || !cnt_enable) begin
      edge_counter <= 6'd1;
      bit_counter  <= 4'd1;
    end else if (edge_counter == prescaler) begin
      edge_counter <= 6'd1;
      bit_counter  <= bit_counter + 4'd1;
    end else begin
      edge_counter <= edge_counter + 6'd1;
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int c0, en_end, done;
    bit fs;
    logic [7:0] d;
    bit pe, se, v;
  } exp_t;
  exp_t q[$];

  logic [7:0] h_pd = 0;
  bit h_pe = 0, h_se = 0, checking = 0;
  int dv_n = 0, dv_cyc = 0;

  always @(negedge CLK) begin
    if (RST && data_valid) begin
      dv_n++;
      dv_cyc = cyc;
    end
  end

  always @(negedge CLK) begin
    logic exp_en;
    if (RST && checking) begin
      exp_en = 0;
      if (q.size() != 0)
        exp_en = (cyc >= q[0].c0 + 1 + SYNC_LAT) && (cyc <= q[0].en_end);
      chk("cnt_enable", {31'd0, cnt_enable}, {31'd0, exp_en});
      if (q.size() != 0 && cyc == q[0].done) begin
        if (!q[0].fs) begin
          chk("done_valid", {31'd0, data_valid}, {31'd0, q[0].v});
          chk("done_pdata", {24'd0, P_DATA}, {24'd0, q[0].d});
          chk("done_par_err", {31'd0, par_err}, {31'd0, q[0].pe});
          chk("done_stp_err", {31'd0, stp_err}, {31'd0, q[0].se});
          h_pd = q[0].d; h_pe = q[0].pe; h_se = q[0].se;
        end else begin
          chk("fs_valid", {31'd0, data_valid}, 32'd0);
        end
        void'(q.pop_front());
      end else begin
        chk("valid_quiet", {31'd0, data_valid}, 32'd0);
        if (q.size() == 0) begin
          chk("hold_pdata", {24'd0, P_DATA}, {24'd0, h_pd});
          chk("hold_par_err", {31'd0, par_err}, {31'd0, h_pe});
          chk("hold_stp_err", {31'd0, stp_err}, {31'd0, h_se});
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Drives one frame cycle by cycle; glitch_at inverts one line cycle, limit>0 truncates the frame.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit typ,
                            input bit par_bit, input bit stop_bit, input int glitch_at,
                            input int limit, output int c0);
    exp_t e;
    int nb, b, off;
    logic v;
    prescaler = 6'(p); PAR_EN = pe; PAR_TYP = typ;
    nb = 10 + (pe ? 1 : 0);
    c0 = cyc;
    e.c0 = c0; e.fs = 0; e.d = d;
    e.pe = pe && (par_bit != (^d ^ typ));
    e.se = !stop_bit;
    e.v  = !e.pe && !e.se;
    e.done = c0 + (nb - 1) * p + p / 2 + 3 + SYNC_LAT;
    e.en_end = e.done - 1;
    q.push_back(e);
    for (int i = 0; i < nb * p; i++) begin
      if (limit > 0 && i >= limit) break;
      b = i / p; off = i % p;
      if (b == 0)                 v = 1'b0;
      else if (b <= 8)            v = d[b-1];
      else if (pe && b == 9)      v = par_bit;
      else                        v = stop_bit ? 1'b1 : (off < p / 2 + 2 ? 1'b0 : 1'b1);
      if (i == glitch_at) v = ~v;
      RX_IN = v;
      tick();
    end
    RX_IN = 1'b1;
  endtask

  task automatic false_start(input int p, input int low_cycles);
    exp_t e;
    prescaler = 6'(p);
    e.c0 = cyc; e.fs = 1; e.d = 0; e.pe = 0; e.se = 0; e.v = 0;
    e.en_end = e.c0 + p / 2 + 2 + SYNC_LAT;
    e.done   = e.en_end + 1;
    q.push_back(e);
    RX_IN = 1'b0;
    repeat (low_cycles) tick();
    RX_IN = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", q.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    int c0, cx;
    RST = 0;
    repeat (3) tick();
    chk("rst_pdata", {24'd0, P_DATA}, 0);
    chk("rst_valid", {31'd0, data_valid}, 0);
    chk("rst_par_err", {31'd0, par_err}, 0);
    chk("rst_stp_err", {31'd0, stp_err}, 0);
    chk("rst_cnt_en", {31'd0, cnt_enable}, 0);
    RST = 1; checking = 1;
    repeat (4) tick();

    false_start(8, 2);
    wait_idle();
    chk("fs_cnt_en_low", {31'd0, cnt_enable}, 0);
    chk("fs_no_pulse", dv_n, 0);

    send_frame(8'hA5, 8, 0, 0, 0, 1, -1, 0, c0);
    wait_idle();
    chk("a5_pdata", {24'd0, P_DATA}, 32'hA5);
    chk("a5_pulses", dv_n, 1);
    chk("a5_latency", dv_cyc - c0, 79 + SYNC_LAT);

    send_frame(8'h3C, 16, 1, 0, 1, 1, -1, 0, c0);
    wait_idle();
    chk("3c_par_err", {31'd0, par_err}, 1);
    chk("3c_pdata", {24'd0, P_DATA}, 32'h3C);
    chk("3c_no_pulse", dv_n, 1);

    send_frame(8'h81, 8, 0, 0, 0, 0, -1, 0, c0);
    wait_idle();
    chk("81_stp_err", {31'd0, stp_err}, 1);
    chk("81_no_pulse", dv_n, 1);

    send_frame(8'h55, 8, 0, 0, 0, 1, -1, 0, c0);
    wait_idle();
    chk("55_stp_clear", {31'd0, stp_err}, 0);
    chk("55_pdata", {24'd0, P_DATA}, 32'h55);
    chk("55_pulses", dv_n, 2);

    send_frame(8'hF0, 8, 0, 0, 0, 1, 8 + 4, 0, c0);
    wait_idle();
    chk("f0_pdata", {24'd0, P_DATA}, 32'hF0);
    chk("f0_pulses", dv_n, 3);

    send_frame(8'h12, 8, 0, 0, 0, 1, -1, 0, c0);
    send_frame(8'h34, 8, 0, 0, 0, 1, -1, 0, cx);
    wait_idle();
    chk("b2b_pulses", dv_n, 5);
    chk("b2b_pdata", {24'd0, P_DATA}, 32'h34);

    send_frame(8'h56, 8, 0, 0, 0, 1, -1, 30, c0);
    chk("mid_cnt_en", {31'd0, cnt_enable}, 1);
    RST = 0;
    #1;
    q.delete();
    h_pd = 0; h_pe = 0; h_se = 0;
    chk("arst_pdata", {24'd0, P_DATA}, 0);
    chk("arst_cnt_en", {31'd0, cnt_enable}, 0);
    chk("arst_valid", {31'd0, data_valid}, 0);
    tick();
    RST = 1;
    repeat (5) tick();
    chk("post_rst_cnt_en", {31'd0, cnt_enable}, 0);
    chk("post_rst_pdata", {24'd0, P_DATA}, 0);
    chk("post_rst_errs", {30'd0, par_err, stp_err}, 0);
    chk("post_rst_pulses", dv_n, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame controller and bit recovery for the UART receiver. It sits directly downstream of the RX edge/bit counter and consumes that counter's edge_counter and bit_counter, and it drives the counter's enable. It detects the start bit, majority-samples each bit, deserializes the data LSB first, checks parity and stop, and emits a one-cycle data_valid with P_DATA.

Parameters:
DATA_WIDTH, 8, payload bits per frame; bit_counter data indices are 2..DATA_WIDTH+1.
PRESC_WIDTH, 6, width of prescaler and edge_counter.

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-low
RX_IN  input  1  serial line, idle high
prescaler  input  PRESC_WIDTH  oversampling ratio; must be even and >=8; stable while cnt_enable=1
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
edge_counter  input  PRESC_WIDTH  from counter; counts 1..prescaler within a bit
bit_counter  input  4  from counter; 1 = start bit, increments when edge_counter==prescaler
cnt_enable  output  1  enable to counter; counter holds 1/1 while low
P_DATA  output  DATA_WIDTH  received payload
data_valid  output  1  one-cycle pulse, payload good
par_err  output  1  parity error of last frame
stp_err  output  1  stop error of last frame

Behaviour:
- Reset: state IDLE; P_DATA=0, data_valid=0, par_err=0, stp_err=0, cnt_enable=0, sample regs=0.
- Sampling:
  - Let H=prescaler/2.
  - RX_IN is registered into s0/s1/s2 on the cycles where edge_counter==H-1, H and H+1 respectively.
  - Decision point (DP) is the cycle edge_counter==H+2.
  - bit = majority(s0,s1,s2).
  - Example, prescaler=8: samples at edges 3,4,5; DP at edge 6.
- cnt_enable is a combinational decode: 1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
- FSM:
  - IDLE: RX_IN==0 -> START. Latch PAR_EN/PAR_TYP into internal regs. Clear par_err, stp_err and P_DATA.
  - START:
    - At DP, bit==1 -> IDLE (false start; no outputs change).
    - At edge_counter==prescaler, bit_counter==1 -> DATA.
  - DATA:
    - At DP, P_DATA[bit_counter-2] <= bit.
    - At edge_counter==prescaler, bit_counter==DATA_WIDTH+1 -> PARITY if latched PAR_EN, else STOP.
  - PARITY:
    - At DP, par_err <= bit != (^P_DATA ^ latched PAR_TYP).
    - At edge_counter==prescaler -> STOP.
  - STOP:
    - At DP, stp_err <= ~bit -> DONE. Exit is at mid-stop bit to absorb clock drift.
  - DONE (one cycle):
    - data_valid=1 iff par_err==0 and stp_err==0.
    - Next state: RX_IN==0 -> START (back-to-back, same actions as IDLE->START, including the latch and clears); else -> IDLE.
- data_valid is registered; it is high exactly one cycle, the DONE cycle.
- P_DATA, par_err and stp_err hold their values until the next START entry.
- par_err is never set when latched PAR_EN=0.
- Async reset mid-frame returns to IDLE immediately; cnt_enable drops, so the counter reinitialises.
- RX_IN activity in IDLE other than a falling level is ignored.

Optional Feature:
Macro RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer (reset value 1) before all FSM and sampling logic. Start detection latency grows by 2 cycles; sample positions are unchanged relative to the synchronized signal.
- Undefined: RX_IN is used directly and is assumed already synchronous to CLK.

Test Plan:
- prescaler=8, PAR_EN=0, frame 0xA5 with stop=1 -> P_DATA=0xA5; data_valid high 1 cycle; par_err=0, stp_err=0.
- prescaler=16, PAR_EN=1, PAR_TYP=0, data 0x3C, parity bit=1 (wrong) -> par_err=1, data_valid stays 0, P_DATA=0x3C.
- prescaler=8, PAR_EN=0, data 0x81, stop bit=0 -> stp_err=1, no data_valid; next good frame 0x55 clears stp_err and pulses valid.
- prescaler=8, RX_IN low for 2 cycles only -> START then IDLE at DP; cnt_enable drops; no valid; no error change.
- prescaler=8, data 0xF0, 1-cycle glitch inverting RX_IN at edge 4 of bit 0 -> majority rejects it; P_DATA=0xF0 with valid.
- Two back-to-back frames 0x12, 0x34 (one stop bit each), then RST low mid-third-frame -> two valid pulses with the correct data; after reset all outputs are 0 and the FSM is in IDLE.
